// File: rtl/vend_pkg.sv
// Shared types for the coin vending block: coin codes, FSM states and coin value lookup.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    HALF = 2'b01,
    ONE  = 2'b10,
    TWO  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    CHANGE   = 2'b10,
    REFUND   = 2'b11
  } state_e;

  // Value in half-yuan units; legality of TWO is decided by the caller.
  function automatic logic [2:0] coin_units(coin_e c);
    case (c)
      HALF:    return 3'd1;
      ONE:     return 3'd2;
      TWO:     return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_chg_out.sv
// Remainder down-counter feeding the change hopper; counts accepted change units.
module vend_chg_out #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          chg_valid,
  input  logic          chg_ready,
  output logic          done
);

  logic [CW-1:0] rem;
  logic          hs;

  assign hs = chg_valid && chg_ready;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                  rem <= '0;
    else if (load)              rem <= load_val;
    else if (hs && rem != '0)   rem <= rem - CW'(1);
  end

  // Nothing left once this edge completes: empty already, or the last unit is taken now.
  assign done = (rem == '0) || (hs && rem == CW'(1));

endmodule

// File: rtl/vend_credit.sv
// Parametrised coin vending controller: credit accumulation, dispense, change and refund.
module vend_credit
  import vend_pkg::*;
#(
  parameter int  PRICE  = 3,
  parameter bit  EN_BIG = 1'b1,
  localparam int CW     = $clog2(PRICE + 4)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [1:0]    coin,
  input  logic          cancel,
  input  logic          chg_ready,
  output logic          dis,
  output logic          chg_valid,
  output logic          coin_rej,
  output logic          busy,
  output logic [CW-1:0] credit
);

  localparam logic [CW-1:0] PRICE_W = CW'(PRICE);

  state_e        state, nxt;
  coin_e         coin_c;
  logic          legal, refund, accept, buy, load, done;
  logic [CW-1:0] sum, load_val;

  always_comb begin
    coin_c   = coin_e'(coin);
    legal    = (coin_c != NONE) && (EN_BIG || coin_c != TWO);
    sum      = credit + CW'(coin_units(coin_c));
    // A live cancel wins over a coin in the same cycle.
    refund   = (state == IDLE) && cancel && (credit != '0);
    accept   = (state == IDLE) && !refund && legal;
    buy      = accept && (sum >= PRICE_W);
    load     = refund || buy;
    load_val = refund ? credit : sum - PRICE_W;
    nxt      = state;
    case (state)
      IDLE:           nxt = refund ? REFUND : (buy ? DISPENSE : IDLE);
      DISPENSE:       nxt = done ? IDLE : CHANGE;
      CHANGE, REFUND: nxt = done ? IDLE : state;
      default:        nxt = IDLE;
    endcase
  end

  vend_chg_out #(.CW(CW)) u_chg (
    .clk       (clk),
    .rst_      (rst_),
    .load      (load),
    .load_val  (load_val),
    .chg_valid (chg_valid),
    .chg_ready (chg_ready),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      credit    <= '0;
      dis       <= 1'b0;
      chg_valid <= 1'b0;
      busy      <= 1'b0;
      coin_rej  <= 1'b0;
    end else begin
      state     <= nxt;
      dis       <= (nxt == DISPENSE);
      chg_valid <= (nxt == CHANGE) || (nxt == REFUND);
      busy      <= (nxt != IDLE);
      coin_rej  <= (coin_c != NONE) && !accept;
      if (load)        credit <= '0;
      else if (accept) credit <= sum;
    end
  end

endmodule

// File: tb/tb_vend_credit.sv
// Bench for vend_credit: EN_BIG=1 (idx 1) and EN_BIG=0 (idx 0) instances share the stimulus.
module tb_vend_credit;

  localparam int PRICE = 3;

  logic clk = 1'b0, rst_ = 1'b1;
  logic [1:0] coin = 2'b00;
  logic cancel = 1'b0, chg_ready = 1'b1;
  logic [1:0] dis, chg_valid, coin_rej, busy;
  logic [1:0][2:0] credit;

  int total = 0, bad = 0;

  vend_credit #(.PRICE(PRICE), .EN_BIG(1'b1)) u1 (
    .clk(clk), .rst_(rst_), .coin(coin), .cancel(cancel), .chg_ready(chg_ready),
    .dis(dis[1]), .chg_valid(chg_valid[1]), .coin_rej(coin_rej[1]), .busy(busy[1]),
    .credit(credit[1]));

  vend_credit #(.PRICE(PRICE), .EN_BIG(1'b0)) u0 (
    .clk(clk), .rst_(rst_), .coin(coin), .cancel(cancel), .chg_ready(chg_ready),
    .dis(dis[0]), .chg_valid(chg_valid[0]), .coin_rej(coin_rej[0]), .busy(busy[0]),
    .credit(credit[0]));

  always #5 clk = ~clk;

  // Model: pending dispense flag, units still to pay out now / after the dispense.
  int m_credit[2], m_units[2], m_pend[2];
  bit m_dis[2], m_rej[2];

  function automatic int coin_val(input logic [1:0] c, input bit big);
    case (c)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return big ? 4 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_) begin : mdl
    int v;
    bit take;
    for (int i = 0; i < 2; i++) begin
      if (!rst_) begin
        m_credit[i] = 0; m_units[i] = 0; m_pend[i] = 0; m_dis[i] = 0; m_rej[i] = 0;
      end else begin
        v = coin_val(coin, i == 1);
        take = 0;
        if (m_dis[i]) begin
          m_dis[i] = 0; m_units[i] = m_pend[i]; m_pend[i] = 0;
        end else if (m_units[i] > 0) begin
          if (chg_ready) m_units[i]--;
        end else if (cancel && m_credit[i] > 0) begin
          m_units[i] = m_credit[i]; m_credit[i] = 0;
        end else if (v > 0) begin
          take = 1;
          if (m_credit[i] + v >= PRICE) begin
            m_dis[i] = 1; m_pend[i] = m_credit[i] + v - PRICE; m_credit[i] = 0;
          end else m_credit[i] += v;
        end
        m_rej[i] = (coin != 2'd0) && !take;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dis[i] !== m_dis[i] || chg_valid[i] !== (m_units[i] > 0) ||
            busy[i] !== (m_dis[i] || m_units[i] > 0) || coin_rej[i] !== m_rej[i] ||
            int'(credit[i]) != m_credit[i]) begin
          bad++;
          $display("FAIL model[%0d] t=%0t got dis=%b chg=%b busy=%b rej=%b cr=%0d want dis=%b chg=%b busy=%b rej=%b cr=%0d",
                   i, $time, dis[i], chg_valid[i], busy[i], coin_rej[i], credit[i],
                   m_dis[i], m_units[i] > 0, m_dis[i] || m_units[i] > 0, m_rej[i], m_credit[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] c, input logic x, input logic r);
    coin = c; cancel = x; chg_ready = r;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 rst_ = 1'b0;
    #1;
    chk("rst_outs", int'({dis[1], chg_valid[1], busy[1], coin_rej[1]}), 0);
    chk("rst_credit", int'(credit[1]), 0);
    #11 rst_ = 1'b1;

    // single-unit coins up to exact price
    cyc(2'd1, 0, 1); chk("t1_cr1", int'(credit[1]), 1);
    cyc(2'd1, 0, 1); chk("t1_cr2", int'(credit[1]), 2);
    cyc(2'd1, 0, 1); chk("t1_dis", int'(dis[1]), 1); chk("t1_nochg", int'(chg_valid[1]), 0);
    chk("t1_cr0", int'(credit[1]), 0);
    cyc(2'd0, 0, 1); chk("t1_dis_off", int'(dis[1]), 0); chk("t1_idle", int'(busy[1]), 0);

    // overpay by 1, then large overpay with hopper stalled
    cyc(2'd2, 0, 1); cyc(2'd2, 0, 1); chk("t2_dis", int'(dis[1]), 1);
    cyc(2'd0, 0, 1); chk("t2_chg", int'(chg_valid[1]), 1); chk("t2_dis_off", int'(dis[1]), 0);
    cyc(2'd0, 0, 1); chk("t2_chg_done", int'(chg_valid[1]), 0); chk("t2_idle", int'(busy[1]), 0);
    cyc(2'd2, 0, 0);
    cyc(2'd3, 0, 0); chk("t2_big_dis", int'(dis[1]), 1);
    chk("t2_nobig_rej", int'(coin_rej[0]), 1); chk("t2_nobig_cr", int'(credit[0]), 2);
    repeat (6) cyc(2'd0, 0, 0);
    chk("t2_stall_valid", int'(chg_valid[1]), 1);
    cyc(2'd0, 0, 1); cyc(2'd0, 0, 1); chk("t2_hs2_valid", int'(chg_valid[1]), 1);
    cyc(2'd0, 0, 1); chk("t2_hs3_done", int'(chg_valid[1]), 0); chk("t2_hs3_idle", int'(busy[1]), 0);
    // drain the EN_BIG=0 instance's credit; cancel at zero credit is ignored on the other
    cyc(2'd0, 1, 1); chk("t2_u0_refund", int'(chg_valid[0]), 1); chk("t2_u0_cr", int'(credit[0]), 0);
    chk("t3_cancel0_ign", int'(busy[1]), 0);
    cyc(2'd0, 0, 1); cyc(2'd0, 0, 1); chk("t2_u0_idle", int'(busy[0]), 0);

    // refund of 2
    cyc(2'd2, 0, 1);
    cyc(2'd0, 1, 0); chk("t3_ref_valid", int'(chg_valid[1]), 1); chk("t3_ref_nodis", int'(dis[1]), 0);
    chk("t3_ref_cr", int'(credit[1]), 0);
    cyc(2'd0, 0, 1); cyc(2'd0, 0, 1); chk("t3_ref_idle", int'(busy[1]), 0);
    cyc(2'd1, 1, 1); chk("t3_c0_coin_cr", int'(credit[1]), 1); chk("t3_c0_norej", int'(coin_rej[1]), 0);

    // coin together with a live cancel
    cyc(2'd2, 1, 1); chk("t5_rej", int'(coin_rej[1]), 1); chk("t5_cr", int'(credit[1]), 0);
    chk("t5_valid", int'(chg_valid[1]), 1);
    cyc(2'd0, 0, 1); chk("t5_rej_off", int'(coin_rej[1]), 0); chk("t5_done", int'(chg_valid[1]), 0);

    // coin while busy leaves the remainder alone
    cyc(2'd2, 0, 0); cyc(2'd2, 0, 0); cyc(2'd0, 0, 0);
    cyc(2'd1, 0, 0); chk("t4_busy_rej", int'(coin_rej[1]), 1); chk("t4_valid", int'(chg_valid[1]), 1);
    cyc(2'd0, 0, 0); chk("t4_rej_off", int'(coin_rej[1]), 0);
    cyc(2'd0, 0, 1); chk("t4_rem1", int'(chg_valid[1]), 0);
    cyc(2'd3, 0, 1); chk("t4_nobig_rej", int'(coin_rej[0]), 1); chk("t4_nobig_cr", int'(credit[0]), 0);
    chk("t4_big_dis", int'(dis[1]), 1);
    cyc(2'd0, 0, 1); cyc(2'd0, 0, 1);

    // async reset in the middle of a payout
    cyc(2'd1, 0, 0); cyc(2'd3, 0, 0); cyc(2'd0, 0, 0);
    chk("t6_pre_valid", int'(chg_valid[1]), 1); chk("t6_pre_cr0", int'(credit[0]), 1);
    rst_ = 1'b0;
    #1;
    chk("t6_rst_valid", int'(chg_valid[1]), 0); chk("t6_rst_busy", int'(busy[1]), 0);
    chk("t6_rst_cr0", int'(credit[0]), 0);
    #3 rst_ = 1'b1;
    cyc(2'd1, 0, 1); chk("t6_fresh_cr", int'(credit[1]), 1);
    cyc(2'd1, 0, 1); cyc(2'd1, 0, 1); chk("t6_fresh_dis", int'(dis[1]), 1);
    cyc(2'd0, 0, 1); chk("t6_fresh_idle", int'(busy[1]), 0);
    repeat (2) cyc(2'd0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
